// File: rtl/mmio_io_periph.sv
// mmio_io_periph
// Purpose : memory-mapped output peripheral decoding a 4-word CPU write window at BASE_ADDR
//           (DISP, LED, DIV, CTRL) and generating the CPU step enable from a programmable
//           prescaler with run/stop and single-step control.
// Ports   : clk, reset (sync, active-high); mem_we/mem_addr/mem_wdata = CPU store bus;
//           disp_o (NUM_DIGITS nibbles), led_o, step_en (1-clk pulse), running_o (run bit),
//           mem_rdata (registered readback, 1-cycle latency).
// Config  : define MMIO_IO_READBACK_EN to build the read mux; otherwise mem_rdata is tied to 0.
// Latency : register writes visible the cycle after the sampling edge; all outputs registered.
// Flow    : no backpressure; a held mem_we simply rewrites the same value each cycle.
//
// Register index is the word offset from BASE_ADDR taken modulo the 16-byte block, so a
// BASE_ADDR that is not 16-byte aligned still maps four distinct registers inside the block
// selected by mem_addr[31:4] (e.g. BASE 0x14: DISP 0x14, LED 0x18, DIV 0x1C, CTRL 0x10).

module mmio_io_periph #(
  parameter logic [31:0]      BASE_ADDR   = 32'h0000_0014,
  parameter int               NUM_DIGITS  = 2,
  parameter int               NUM_LEDS    = 4,
  parameter int               DIV_W       = 20,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 20'hFFFFF,
  parameter logic             RESET_RUN   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_we,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  output logic [4*NUM_DIGITS-1:0] disp_o,
  output logic [NUM_LEDS-1:0]     led_o,
  output logic                    step_en,
  output logic                    running_o,
  output logic [31:0]             mem_rdata
);

  localparam int DW = 4*NUM_DIGITS;

  // ---------------------------------------------------------------- decode
  logic       in_win;
  logic       hit;
  logic [1:0] idx;
  logic       hit_disp, hit_led, hit_div, hit_ctrl;

  assign in_win   = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign hit      = mem_we && in_win && (mem_addr[1:0] == 2'b00);
  assign idx      = mem_addr[3:2] - BASE_ADDR[3:2];
  assign hit_disp = hit && (idx == 2'd0);
  assign hit_led  = hit && (idx == 2'd1);
  assign hit_div  = hit && (idx == 2'd2);
  assign hit_ctrl = hit && (idx == 2'd3);

  // ---------------------------------------------------------------- state
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic             prev_hit;   // CTRL was hit last cycle
  logic             tick;       // prescaler terminal count this cycle
  logic             step_req;   // accepted single-step request

  // Only the first cycle of a contiguous CTRL hit run may request a step.
  assign step_req = hit_ctrl && mem_wdata[1] && !prev_hit;

  // Priority: DIV write reload (suppresses the pulse), then run 0->1 reload,
  // then normal counting while running.
  always_comb begin
    cnt_nxt = cnt;
    tick    = 1'b0;
    if (hit_div) begin
      cnt_nxt = mem_wdata[DIV_W-1:0];
    end else if (hit_ctrl && mem_wdata[0] && !running_o) begin
      cnt_nxt = div;
    end else if (running_o) begin
      if (cnt == '0) begin
        tick    = 1'b1;
        cnt_nxt = div;
      end else begin
        cnt_nxt = cnt - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_o    <= '0;
      led_o     <= '0;
      div       <= DEFAULT_DIV;
      cnt       <= DEFAULT_DIV;
      running_o <= RESET_RUN;
      prev_hit  <= 1'b0;
      step_en   <= 1'b0;
    end else begin
      if (hit_disp) disp_o    <= mem_wdata[DW-1:0];
      if (hit_led)  led_o     <= mem_wdata[NUM_LEDS-1:0];
      if (hit_div)  div       <= mem_wdata[DIV_W-1:0];
      if (hit_ctrl) running_o <= mem_wdata[0];
      cnt      <= cnt_nxt;
      prev_hit <= hit_ctrl;
      // Prescaler and single-step pulses merge into one pulse when coincident.
      step_en  <= tick || step_req;
    end
  end

  // ---------------------------------------------------------------- readback
`ifdef MMIO_IO_READBACK_EN
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (in_win && (mem_addr[1:0] == 2'b00)) begin
      case (idx)
        2'd0:    rd_mux[DW-1:0]       = disp_o;
        2'd1:    rd_mux[NUM_LEDS-1:0] = led_o;
        2'd2:    rd_mux[DIV_W-1:0]    = div;
        default: rd_mux[0]            = running_o;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) mem_rdata <= '0;
    else       mem_rdata <= rd_mux;
  end
`else
  assign mem_rdata = 32'h0;
`endif

  // Upper write-data bits beyond the widest register field are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^mem_wdata;

endmodule

// File: tb/tb_mmio_io_periph.sv
// tb_mmio_io_periph
// Randomized stimulus against a behavioural model of the register map and step generator.
// DEFAULT_DIV is reduced so the post-reset prescaler period stays short.

module tb_mmio_io_periph;

  localparam logic [31:0] BASE   = 32'h0000_0014;
  localparam int          DEFDIV = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [7:0]  disp_o;
  logic [3:0]  led_o;
  logic        step_en;
  logic        running_o;
  logic [31:0] mem_rdata;

  mmio_io_periph #(
    .BASE_ADDR  (BASE),
    .NUM_DIGITS (2),
    .NUM_LEDS   (4),
    .DIV_W      (20),
    .DEFAULT_DIV(20'(DEFDIV)),
    .RESET_RUN  (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .disp_o   (disp_o),
    .led_o    (led_o),
    .step_en  (step_en),
    .running_o(running_o),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------------ reference model
  logic [7:0]  m_disp;
  logic [3:0]  m_led;
  logic [19:0] m_div;
  int          m_left;   // clk edges remaining until the next prescaler pulse minus one
  logic        m_run;
  logic        m_prev;
  logic        m_step;
  logic [31:0] m_rdata;

  function automatic void model_edge(input logic rst, input logic we,
                                     input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    logic [31:0] rd;
    bit          inwin, hit, ctrl, pulse;
    off   = (a - BASE) % 32'd16;
    inwin = (a / 32'd16) == (BASE / 32'd16);
    rd    = 32'h0;
`ifdef MMIO_IO_READBACK_EN
    if (inwin && (a % 32'd4) == 0) begin
      if (off == 0)       rd = {24'h0, m_disp};
      else if (off == 4)  rd = {28'h0, m_led};
      else if (off == 8)  rd = {12'h0, m_div};
      else                rd = {31'h0, m_run};
    end
`endif
    if (rst) begin
      m_disp = 0; m_led = 0; m_div = 20'(DEFDIV); m_left = DEFDIV;
      m_run = 1'b1; m_prev = 0; m_step = 0; m_rdata = 0;
      return;
    end
    hit   = we && inwin && ((a % 32'd4) == 0);
    ctrl  = hit && off == 12;
    pulse = 0;
    if (hit && off == 8) begin
      m_div  = d[19:0];
      m_left = int'(d[19:0]);
    end else if (ctrl && d[0] && !m_run) begin
      m_left = int'(m_div);
    end else if (m_run) begin
      if (m_left == 0) begin
        pulse  = 1;
        m_left = int'(m_div);
      end else begin
        m_left = m_left - 1;
      end
    end
    m_step = pulse || (ctrl && d[1] && !m_prev);
    if (hit && off == 0) m_disp = d[7:0];
    if (hit && off == 4) m_led  = d[3:0];
    if (ctrl)            m_run  = d[0];
    m_prev  = ctrl;
    m_rdata = rd;
  endfunction

  wire [45:0] obs = {disp_o, led_o, step_en, running_o, mem_rdata};
  wire [45:0] exp_v = {m_disp, m_led, m_step, m_run, m_rdata};
  localparam logic [45:0] RESET_VEC = {8'h00, 4'h0, 1'b0, 1'b1, 32'h0};

  // Drive one cycle, advance the model at the edge, sample 1 ns later.
  task automatic cyc(input logic rst, input logic we, input logic [31:0] a, input logic [31:0] d);
    reset = rst; mem_we = we; mem_addr = a; mem_wdata = d;
    @(posedge clk);
    model_edge(rst, we, a, d);
    #1;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    cyc(1, 1, 32'h14, $urandom);
    cyc(1, 1, 32'h18, $urandom);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL reset_values got=%h want=%h", obs, RESET_VEC);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_model got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_disp_hold();
    logic [31:0] d;
    d = 32'h0000_003C;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 32'h14, d);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL disp_hold cyc%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    checks++;
    if (disp_o !== 8'h3C || led_o !== 4'h0 || running_o !== 1'b1) begin
      errors++; $display("FAIL disp_value got=%h/%h/%b want=3c/0/1", disp_o, led_o, running_o);
    end
    d = $urandom;
    cyc(0, 1, 32'h14, d);
    cyc(0, 0, 0, 0);
    checks++;
    if (disp_o !== d[7:0]) begin
      errors++; $display("FAIL disp_random got=%h want=%h", disp_o, d[7:0]);
    end
  endtask

  task automatic test_decode();
    logic [7:0]  sd;
    logic [3:0]  sl;
    logic [31:0] bad [4];
    sd = disp_o; sl = led_o;
    bad[0] = 32'h15; bad[1] = 32'h24; bad[2] = 32'h1A;
    bad[3] = ($urandom & 32'hFFFF_FF00) | 32'h100 | 32'h14;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, bad[i], $urandom);
      checks++;
      if (disp_o !== sd || led_o !== sl || obs !== exp_v) begin
        errors++; $display("FAIL decode_ignore addr=%h got=%h want=%h", bad[i], obs, exp_v);
      end
    end
    cyc(0, 1, 32'h18, 32'hF);
    cyc(0, 0, 0, 0);
    checks++;
    if (led_o !== 4'hF || disp_o !== sd) begin
      errors++; $display("FAIL led_write got=%h/%h want=f/%h", led_o, disp_o, sd);
    end
  endtask

  task automatic test_prescaler();
    int first, cnt;
    cyc(0, 1, 32'h1C, 32'd3);
    checks++;
    if (step_en !== 1'b0 || obs !== exp_v) begin
      errors++; $display("FAIL div_write_nopulse got=%h want=%h", obs, exp_v);
    end
    first = -1; cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 0, 0);
      if (step_en === 1'b1) begin cnt++; if (first < 0) first = k; end
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL presc3 k=%0d got=%h want=%h", k, obs, exp_v);
      end
    end
    checks++;
    if (first != 3 || cnt != 4) begin
      errors++; $display("FAIL presc3_timing got first=%0d n=%0d want first=3 n=4", first, cnt);
    end
    cyc(0, 1, 32'h1C, 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (step_en !== 1'b1) begin
        errors++; $display("FAIL presc0 k=%0d got=%b want=1", k, step_en);
      end
    end
    for (int r = 0; r < 3; r++) begin
      cyc(0, 1, 32'h1C, 32'($urandom_range(1, 6)));
      for (int k = 0; k < 16; k++) begin
        cyc(0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
          errors++; $display("FAIL presc_rand r=%0d k=%0d got=%h want=%h", r, k, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_single_step();
    int first, cnt;
    cyc(0, 1, 32'h10, 32'h0);
    cyc(0, 0, 0, 0);
    first = -1; cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 32'h10, 32'h2);
      if (step_en === 1'b1) begin cnt++; if (first < 0) first = k; end
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL step_hold k=%0d got=%h want=%h", k, obs, exp_v);
      end
    end
    checks++;
    if (first != 0 || cnt != 1 || running_o !== 1'b0) begin
      errors++; $display("FAIL step_once got first=%0d n=%0d run=%b want 0/1/0", first, cnt, running_o);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h10, 32'h2);
    checks++;
    if (step_en !== 1'b1) begin
      errors++; $display("FAIL step_rewrite got=%b want=1", step_en);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (step_en !== 1'b0) begin
      errors++; $display("FAIL step_clear got=%b want=0", step_en);
    end
    cyc(0, 1, 32'h10, 32'h3);
    checks++;
    if (step_en !== 1'b1 || running_o !== 1'b1) begin
      errors++; $display("FAIL run_step got=%b/%b want=1/1", step_en, running_o);
    end
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL run_resume k=%0d got=%h want=%h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_midcount();
    int k, first;
    cyc(0, 1, 32'h1C, 32'd3);
    k = 0;
    while (m_left != 1 && k < 10) begin cyc(0, 0, 0, 0); k++; end
    checks++;
    if (m_left != 1) begin
      errors++; $display("FAIL midcount_reach got=%0d want=1", m_left);
    end
    cyc(1, 1, 32'h14, 32'hA5);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL midcount_reset got=%h want=%h", obs, RESET_VEC);
    end
    first = -1;
    for (int j = 0; j < DEFDIV + 4 && first < 0; j++) begin
      cyc(0, 0, 0, 0);
      if (step_en === 1'b1) first = j;
    end
    checks++;
    if (first != DEFDIV) begin
      errors++; $display("FAIL reset_first_pulse got=%0d want=%0d", first, DEFDIV);
    end
  endtask

  task automatic test_readback();
    cyc(0, 1, 32'h1C, 32'h123);
    cyc(0, 0, 32'h1C, 32'h0);
`ifdef MMIO_IO_READBACK_EN
    checks++;
    if (mem_rdata !== 32'h123) begin
      errors++; $display("FAIL rd_div got=%h want=00000123", mem_rdata);
    end
`else
    checks++;
    if (mem_rdata !== 32'h0) begin
      errors++; $display("FAIL rd_tied got=%h want=0", mem_rdata);
    end
`endif
    cyc(0, 0, 32'h40, 32'h0);
    checks++;
    if (mem_rdata !== 32'h0) begin
      errors++; $display("FAIL rd_outside got=%h want=0", mem_rdata);
    end
    cyc(0, 1, 32'h1C, 32'd5);
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic        rst;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h10;
        1: a = 32'h14;
        2: a = 32'h18;
        3: a = 32'h1C;
        4: a = 32'h10 + 32'($urandom_range(1, 15));
        default: a = $urandom;
      endcase
      d = $urandom;
      if (a == 32'h1C) d = (d & 32'hFFF0_0000) | 32'($urandom_range(0, 7));
      rst = ($urandom_range(0, 49) == 0);
      cyc(rst, 1'($urandom_range(0, 1)), a, d);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL random i=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_disp_hold();
    test_decode();
    test_prescaler();
    test_single_step();
    test_reset_midcount();
    test_readback();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
